// File: rtl/pwm_v3.sv
// rtl/pwm_v3.sv - fixed-frequency PWM, duty in eighths of a PERIOD-clock frame
// The duty code is shadowed at frame start, so mid-frame changes cannot cause runt pulses.
module pwm_v3 #(
  parameter logic [27:0] PERIOD = 28'd100000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  dutyCycle,
  output logic        PWM_pulse,
  output logic [27:0] debugCounter
);

  logic [27:0] r_cnt;
  logic [2:0]  r_duty;
  logic        r_pulse;

  logic        w_wrap;
  logic [27:0] w_cnt_next;
  logic [2:0]  w_duty_next;
  logic [30:0] w_prod;
  logic [27:0] w_thr_next;

  assign w_wrap      = (r_cnt == PERIOD - 28'd1);
  assign w_cnt_next  = w_wrap ? 28'd0 : r_cnt + 28'd1;
  assign w_duty_next = w_wrap ? dutyCycle : r_duty;

  // 31-bit product cannot overflow for any 28-bit PERIOD times a 3-bit code
  assign w_prod     = 31'(PERIOD) * 31'(w_duty_next);
  assign w_thr_next = 28'(w_prod >> 3);

  // Output register is fed from next-state values so it matches debugCounter every cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt   <= 28'd0;
      r_duty  <= 3'd0;
      r_pulse <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_duty  <= w_duty_next;
      r_pulse <= (w_cnt_next < w_thr_next);
    end
  end

  assign PWM_pulse    = r_pulse;
  assign debugCounter = r_cnt;

endmodule

// File: tb/tb_pwm_v3.sv
// tb/tb_pwm_v3.sv - randomized self-checking bench for pwm_v3 against a frame-level model
module tb_pwm_v3;
  localparam int P = 2500;

  logic        clock;
  logic        reset;
  logic [2:0]  dutyCycle;
  logic        PWM_pulse;
  logic [27:0] debugCounter;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: clocks since reset release and the code captured for each frame
  int t;
  int fd [0:63];
  int hc;
  int rises;
  int prev_pwm;
  int high_tbl [0:7] = '{0, 312, 625, 937, 1250, 1562, 1875, 2187};

  pwm_v3 #(.PERIOD(28'd2500)) dut (
    .clock        (clock),
    .reset        (reset),
    .dutyCycle    (dutyCycle),
    .PWM_pulse    (PWM_pulse),
    .debugCounter (debugCounter)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", tag, got, exp, t);
    end
  endtask

  task automatic model_reset();
    t        = 0;
    fd[0]    = 0;
    hc       = 0;
    rises    = 0;
    prev_pwm = 0;
  endtask

  task automatic tick();
    int pos;
    int fr;
    int thr;
    @(posedge clock);
    t++;
    if (t % P == 0) fd[t / P] = int'(dutyCycle);
    @(negedge clock);
    pos = t % P;
    fr  = t / P;
    thr = (P * fd[fr]) / 8;
    check("cnt", int'(debugCounter), pos);
    check("pwm", int'(PWM_pulse), (pos < thr) ? 1 : 0);
    if (PWM_pulse) hc++;
    if (PWM_pulse && prev_pwm == 0) rises++;
    prev_pwm = int'(PWM_pulse);
    if (pos == P - 1) begin
      check("frame_high", hc, high_tbl[fd[fr]]);
      check("frame_edges", rises, (fd[fr] > 0) ? 1 : 0);
      hc    = 0;
      rises = 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int pos);
    tick();
    while (t % P != pos) tick();
  endtask

  initial begin
    reset     = 1'b1;
    dutyCycle = 3'd0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_pwm", int'(PWM_pulse), 0);
    check("reset_cnt", int'(debugCounter), 0);
    reset = 1'b0;
    model_reset();

    // First frame stays low even though a nonzero code is presented
    dutyCycle = 3'd5;
    run(P + 10);

    // Duty sweep
    for (int c = 1; c <= 8; c++) begin
      dutyCycle = 3'(c % 8);
      run(5000);
    end

    // Mid-frame change from code 2 to 7 at counter 1000
    dutyCycle = 3'd2;
    run_to(0);
    run_to(1000);
    dutyCycle = 3'd7;
    run_to(0);
    run(P);

    // Change presented just before the wrap edge
    for (int k = 0; k < 2; k++) begin
      run_to(P - 1);
      dutyCycle = 3'($urandom_range(1, 7));
      run(P);
    end

    // Random code changes at random times
    for (int k = 0; k < 8; k++) begin
      dutyCycle = 3'($urandom_range(0, 7));
      run($urandom_range(200, 2000));
    end

    // Asynchronous reset in the middle of a code-5 high interval
    dutyCycle = 3'd5;
    run_to(0);
    run_to(500);
    check("pre_reset_pwm", int'(PWM_pulse), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_pwm", int'(PWM_pulse), 0);
    check("async_reset_cnt", int'(debugCounter), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("held_reset_pwm", int'(PWM_pulse), 0);
      check("held_reset_cnt", int'(debugCounter), 0);
    end
    reset = 1'b0;
    model_reset();
    run(2 * P);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
